// File: rtl/song_pkg.sv
// Shared constants for the song play controller: state encodings and the
// default one-second prescaler terminal count used alongside song_timing.
package song_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] COUNTDOWN = 3'd1;
    localparam logic [STATE_W-1:0] PLAYING   = 3'd2;
    localparam logic [STATE_W-1:0] PAUSED    = 3'd3;
    localparam logic [STATE_W-1:0] DONE      = 3'd4;

    localparam logic [24:0] DEFAULT_DELAY = 25'd26_999_999;

endpackage

// File: rtl/song_sequencer_if.sv
// Link between the play controller and the song_timing / note-memory side.
interface song_sequencer_if;

    logic       start_song;
    logic       pause_song;
    logic       mem_play;
    logic       song_done;
    logic [7:0] seconds;

    modport master (
        output start_song,
        output pause_song,
        output mem_play,
        input  song_done,
        input  seconds
    );

    modport slave (
        input  start_song,
        input  pause_song,
        input  mem_play,
        output song_done,
        output seconds
    );

endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button level.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    // History resets high so a button held through reset yields no edge.
    always_ff @(posedge clk) begin
        if (reset) btn_q <= 1'b1;
        else       btn_q <= btn;
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/song_sequencer.sv
// Play controller for one song run: 3-2-1 countdown, play/pause sequencing of
// song_timing and end-of-run detection on song_done or an elapsed-time limit.
module song_sequencer
    import song_pkg::*;
#(
    parameter logic [24:0] DELAY       = DEFAULT_DELAY,
    parameter int          COUNT_SECS  = 3,
    parameter logic [7:0]  MAX_SECONDS = 8'd240
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               pause_btn,
    song_sequencer_if.master   bus,
    output logic [STATE_W-1:0] state,
    output logic [1:0]         countdown,
    output logic               game_over,
    output logic               timed_out
);

    localparam logic [1:0] CNT_LOAD = 2'(COUNT_SECS);

    logic               start_e;
    logic               pause_e;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [24:0]        prescaler_q;
    logic [1:0]         countdown_q;
    logic               start_song_q;
    logic               timed_out_q;
    logic               wrap;
    logic               live;

    btn_edge u_start_edge (.clk(clk), .reset(reset), .btn(start_btn), .rise(start_e));
    btn_edge u_pause_edge (.clk(clk), .reset(reset), .btn(pause_btn), .rise(pause_e));

    assign wrap = (prescaler_q == DELAY);
    // seconds and song_done are stale from the previous run while start_song is high.
    assign live = ~start_song_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_e) state_d = COUNTDOWN;
            COUNTDOWN: if (wrap && countdown_q == 2'd1) state_d = PLAYING;
            PLAYING: begin
                if (live && bus.song_done)                 state_d = DONE;
                else if (live && bus.seconds >= MAX_SECONDS) state_d = DONE;
                else if (pause_e)                          state_d = PAUSED;
            end
            PAUSED: begin
                if (start_e)            state_d = COUNTDOWN;
                else if (bus.song_done) state_d = DONE;
                else if (pause_e)       state_d = PLAYING;
            end
            DONE:      if (start_e) state_d = COUNTDOWN;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q  <= '0;
            countdown_q  <= '0;
            start_song_q <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            start_song_q <= (state_q == COUNTDOWN) && (state_d == PLAYING);

            if (state_d == COUNTDOWN && state_q != COUNTDOWN) begin
                prescaler_q <= '0;
                countdown_q <= CNT_LOAD;
            end else if (state_q == COUNTDOWN) begin
                prescaler_q <= wrap ? 25'd0 : prescaler_q + 25'd1;
                if (wrap) countdown_q <= countdown_q - 2'd1;
            end else begin
                prescaler_q <= '0;
                countdown_q <= '0;
            end

            // Only PLAYING can time out; a simultaneous song_done wins.
            if (state_d == DONE && state_q != DONE)
                timed_out_q <= (state_q == PLAYING) && !bus.song_done;
            else if (state_q == DONE && state_d != DONE)
                timed_out_q <= 1'b0;
        end
    end

    always_comb begin
        state          = state_q;
        countdown      = (state_q == COUNTDOWN) ? countdown_q : 2'd0;
        game_over      = (state_q == DONE);
        timed_out      = timed_out_q;
        bus.start_song = start_song_q;
        bus.pause_song = (state_q != PLAYING);
        bus.mem_play   = (state_q == PLAYING);
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed, table-driven bench for song_sequencer with a short prescaler.
module tb_song_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_btn;
    logic       pause_btn;
    logic [2:0] state;
    logic [1:0] countdown;
    logic       game_over;
    logic       timed_out;

    int tests  = 0;
    int failed = 0;

    song_sequencer_if bus();

    song_sequencer #(
        .DELAY(25'd3),
        .COUNT_SECS(3),
        .MAX_SECONDS(8'd5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_btn(start_btn),
        .pause_btn(pause_btn),
        .bus(bus),
        .state(state),
        .countdown(countdown),
        .game_over(game_over),
        .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       start;
        logic       pause;
        logic       done;
        logic [7:0] secs;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Packs {state, countdown, start_song, pause_song, mem_play, game_over, timed_out}.
    function automatic logic [9:0] o(int st, int cd, bit ss, bit ps, bit mp, bit go, bit to);
        logic [2:0] s3;
        logic [1:0] c2;
        s3 = st[2:0];
        c2 = cd[1:0];
        return {s3, c2, ss, ps, mp, go, to};
    endfunction

    function automatic void add(string n, bit st, bit pa, bit dn, int sc, logic [9:0] e);
        vec_t v;
        v.name  = n;
        v.start = st;
        v.pause = pa;
        v.done  = dn;
        v.secs  = sc[7:0];
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    function automatic logic [9:0] outs();
        return {state, countdown, bus.start_song, bus.pause_song, bus.mem_play, game_over, timed_out};
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(bit st, bit pa, bit dn, int sc);
        start_btn     = st;
        pause_btn     = pa;
        bus.song_done = dn;
        bus.seconds   = sc[7:0];
    endtask

    initial begin
        // Main scenario: countdown, pulse, pause/resume, timeout, replay, masked stale song_done.
        add("cd_load", 1, 0, 0, 0, o(1, 3, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) add("cd3", 0, 0, 0, 0, o(1, 3, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) add("cd2", 0, 0, 0, 0, o(1, 2, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) add("cd1", 0, 0, 0, 0, o(1, 1, 0, 1, 0, 0, 0));
        add("start_pulse", 0, 0, 0, 0, o(2, 0, 1, 0, 1, 0, 0));
        add("playing",     0, 0, 0, 0, o(2, 0, 0, 0, 1, 0, 0));
        add("pause",       0, 1, 0, 0, o(3, 0, 0, 1, 0, 0, 0));
        add("paused_hold", 0, 0, 0, 0, o(3, 0, 0, 1, 0, 0, 0));
        add("resume",      0, 1, 0, 0, o(2, 0, 0, 0, 1, 0, 0));
        add("resumed",     0, 0, 0, 0, o(2, 0, 0, 0, 1, 0, 0));
        add("timeout",     0, 0, 0, 5, o(4, 0, 0, 1, 0, 1, 1));
        add("done_hold",   0, 1, 0, 5, o(4, 0, 0, 1, 0, 1, 1));
        add("replay",      1, 0, 0, 5, o(1, 3, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) add("re_cd3", 0, 0, 1, 5, o(1, 3, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) add("re_cd2", 0, 0, 1, 5, o(1, 2, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) add("re_cd1", 0, 0, 1, 5, o(1, 1, 0, 1, 0, 0, 0));
        add("re_start_pulse", 0, 0, 1, 5, o(2, 0, 1, 0, 1, 0, 0));
        add("stale_masked",   0, 0, 1, 5, o(2, 0, 0, 0, 1, 0, 0));
        add("done_beats_to",  0, 0, 1, 5, o(4, 0, 0, 1, 0, 1, 0));

        // Start held through reset must not register as an edge.
        reset = 1'b1;
        drive(1, 0, 0, 0);
        cyc(2);
        chk("reset_outs", 32'(outs()), 32'(o(0, 0, 0, 1, 0, 0, 0)));
        reset = 1'b0;
        cyc(3);
        chk("held_no_edge", 32'(state), 32'd0);
        drive(0, 0, 0, 0);
        cyc(1);
        chk("release_idle", 32'(state), 32'd0);
        drive(1, 0, 0, 0);
        cyc(1);
        chk("fresh_rise", 32'({state, countdown}), 32'({3'd1, 2'd3}));
        drive(0, 0, 0, 0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(2);

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].pause, vecs[i].done, int'(vecs[i].secs));
            cyc(1);
            chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end

        // From PAUSED, simultaneous start and pause edges restart the countdown.
        drive(1, 0, 0, 0);
        cyc(1);
        drive(0, 0, 0, 0);
        cyc(12);
        chk("p_playing", 32'(state), 32'd2);
        drive(0, 1, 0, 0);
        cyc(1);
        chk("p_paused", 32'(state), 32'd3);
        drive(0, 0, 0, 0);
        cyc(1);
        drive(1, 1, 0, 0);
        cyc(1);
        chk("paused_restart", 32'(outs()), 32'(o(1, 3, 0, 1, 0, 0, 0)));
        drive(0, 0, 0, 0);
        cyc(2);
        chk("mid_cd_presc", 32'(dut.prescaler_q), 32'd2);
        reset = 1'b1;
        cyc(1);
        chk("mid_reset_outs", 32'(outs()), 32'(o(0, 0, 0, 1, 0, 0, 0)));
        chk("mid_reset_presc", 32'(dut.prescaler_q), 32'd0);
        reset = 1'b0;
        cyc(2);
        chk("post_reset_idle", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Top-level play controller for one song run. It edge-detects the debounced start/pause buttons and runs a 3-2-1 countdown. It then sequences the song_timing counter through start_song/pause_song and ends the run on song_done from note memory or on an elapsed-time limit. Its state, countdown and game_over outputs drive graphics/display and note-memory enable.

Parameters:
DELAY, 27000000-1, prescaler terminal count; one second = DELAY+1 clk cycles.
COUNT_SECS, 3, countdown length in seconds (1..3).
MAX_SECONDS, 8'd240, elapsed-seconds limit that ends a song as timed out.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_btn  in  1  debounced start button, level
pause_btn  in  1  debounced pause button, level
song_done  in  1  end-of-song flag from note memory, level
seconds  in  8  elapsed seconds from song_timing
start_song  out  1  one-cycle pulse to song_timing (clear and start)
pause_song  out  1  level to song_timing; high whenever not PLAYING
mem_play  out  1  note-memory read enable; high in PLAYING
state  out  3  current state encoding
countdown  out  2  seconds remaining in COUNTDOWN, else 0
game_over  out  1  high in DONE
timed_out  out  1  high in DONE if the run ended by MAX_SECONDS

Behaviour:
- Reset values:
  - state=IDLE; countdown=0; prescaler=0.
  - start_song=0, pause_song=1, mem_play=0, game_over=0, timed_out=0.
  - Button history registers reset to 1, so a button held through reset does not produce an edge.
- Edges: start_e = start_btn & ~start_q, pause_e = pause_btn & ~pause_q. Both are registered history, with a one-cycle response.
- State encodings: IDLE=0, COUNTDOWN=1, PLAYING=2, PAUSED=3, DONE=4.
- IDLE:
  - start_e -> COUNTDOWN, with countdown<=COUNT_SECS and prescaler<=0.
  - pause_e is ignored.
- COUNTDOWN:
  - prescaler increments every cycle and wraps to 0 when it equals DELAY.
  - On a wrap with countdown>1, countdown decrements.
  - On a wrap with countdown==1: countdown<=0, state<=PLAYING, start_song<=1.
  - The countdown takes exactly COUNT_SECS*(DELAY+1) cycles from the edge cycle.
  - Start/pause edges are ignored.
- PLAYING:
  - start_song is high only in the first PLAYING cycle. In that cycle, song_done and the timeout compare are masked, because seconds and memory are still stale from the previous run.
  - Otherwise, priority is: song_done -> DONE (timed_out<=0); else seconds>=MAX_SECONDS -> DONE (timed_out<=1); else pause_e -> PAUSED.
- PAUSED:
  - Priority is: start_e -> COUNTDOWN (restart, reload as in IDLE); else song_done -> DONE (timed_out<=0); else pause_e -> PLAYING.
  - Resuming does not pulse start_song.
- DONE:
  - start_e -> COUNTDOWN (replay), with timed_out<=0 on exit.
  - Pause edges are ignored.
- Outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- prescaler is 25 bits and is held at 0 outside COUNTDOWN.
- seconds saturates at 8'hFF in song_timing. MAX_SECONDS>8'hFF is illegal.
- Reset mid-run from any state returns to IDLE on the next edge, with all outputs at their reset values.
- Illegal state encodings (5-7) go to IDLE.

Decomposition:
- Package song_pkg holds:
  - the state localparams IDLE..DONE and STATE_W=3;
  - the default DELAY, shared with song_timing.
- Sub-module btn_edge: clk, reset, btn in, rise out. It holds the history register, which resets to 1. It is instantiated twice.

Test Plan:
1. With DELAY=3, COUNT_SECS=3: reset, then start_btn rises -> countdown reads 3,2,1 for 4 cycles each. start_song pulses for exactly one cycle in the 13th cycle after the edge, state=2, and pause_song falls in the same cycle.
2. With start_btn held high through reset and released after reset: there is no transition, and state stays 0. A fresh rise then gives COUNTDOWN.
3. In PLAYING, pause rise -> state=3, pause_song=1, mem_play=0. A second pause rise -> state=2 with no start_song pulse.
4. In PLAYING with MAX_SECONDS=5, drive seconds=5 -> DONE, timed_out=1, game_over=1. A start rise then gives COUNTDOWN with timed_out=0.
5. song_done=1 and seconds=MAX_SECONDS in the same cycle -> DONE with timed_out=0. Separately, song_done held high from the previous run during the start_song cycle does not end the run in that cycle.
6. In PAUSED, start and pause rise in the same cycle -> COUNTDOWN with countdown=3. Reset asserted mid-COUNTDOWN -> IDLE, countdown=0, prescaler=0.
